branch_resolve: RTL and testbench

- Sits downstream of the fetch-stage branch predictor, in the EX stage.
- Holds the prediction made for each in-flight conditional branch or jalr in an in-order queue.
- Checks each prediction against the actual EX outcome. On a mispredict it generates the flush/redirect, and every resolved branch produces a registered update strobe back to the predictor tables (BHT/BTT/direction/loop).
- Owns wrong-path cleanup of the queue.

---
 rtl/branch_resolve_if.sv | 40 ++++
 rtl/branch_resolve.sv | 130 +++++++++++++
 tb/tb_branch_resolve.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode push, EX resolve, redirect and predictor-update bus of branch_resolve.
// The master modport is the pipeline side; the slave modport is branch_resolve.
interface branch_resolve_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  dec_br_push;
   logic [ADDR_WIDTH-1:0] dec_br_pc;
   logic                  dec_pred_taken;
   logic [ADDR_WIDTH-1:0] dec_pred_target;
   logic                  dec_is_loop;
   logic                  dec_stall;
   logic                  ex_br_valid;
   logic                  ex_is_jalr;
   logic                  ex_taken;
   logic [ADDR_WIDTH-1:0] ex_target;
   logic                  ext_flush;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  upd_valid;
   logic [ADDR_WIDTH-1:0] upd_pc;
   logic                  upd_taken;
   logic [ADDR_WIDTH-1:0] upd_target;
   logic                  upd_is_loop;
   logic                  upd_jalr;
   logic                  q_err;

   modport master (
      output dec_br_push, dec_br_pc, dec_pred_taken, dec_pred_target, dec_is_loop,
      output ex_br_valid, ex_is_jalr, ex_taken, ex_target, ext_flush,
      input  dec_stall, redirect_valid, redirect_pc,
      input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_loop, upd_jalr, q_err
   );

   modport slave (
      input  dec_br_push, dec_br_pc, dec_pred_taken, dec_pred_target, dec_is_loop,
      input  ex_br_valid, ex_is_jalr, ex_taken, ex_target, ext_flush,
      output dec_stall, redirect_valid, redirect_pc,
      output upd_valid, upd_pc, upd_taken, upd_target, upd_is_loop, upd_jalr, q_err
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage check of queued branch predictions, mispredict redirect and predictor update.
// Define BRANCH_STATS_EN to add saturating resolve / mispredict / target-miss counters.
module branch_resolve #(
   parameter int ADDR_WIDTH = 32,
   parameter int QDEPTH     = 4,
   parameter int QPTR_W     = $clog2(QDEPTH)
) (
   input  logic            cpu_clk,
   input  logic            cpu_rst,
   branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_resolved,
   output logic [31:0]     stat_mispred,
   output logic [31:0]     stat_target_miss
`endif
);

   localparam logic [QPTR_W:0] FULL_CNT = (QPTR_W+1)'(QDEPTH);

   logic [ADDR_WIDTH-1:0] q_pc     [QDEPTH];
   logic [ADDR_WIDTH-1:0] q_target [QDEPTH];
   logic                  q_taken  [QDEPTH];
   logic                  q_loop   [QDEPTH];

   logic [QPTR_W-1:0]     rd_ptr, wr_ptr;
   logic [QPTR_W:0]       count;

   logic                  push_ok, pop, mis, clear;
   logic [ADDR_WIDTH-1:0] head_pc, head_target;
   logic                  head_taken, head_loop;

   assign bus.dec_stall = (count == FULL_CNT);
   assign push_ok       = bus.dec_br_push && !bus.dec_stall;
   assign pop           = bus.ex_br_valid && (count != '0);

   assign head_pc     = q_pc[rd_ptr];
   assign head_target = q_target[rd_ptr];
   assign head_taken  = q_taken[rd_ptr];
   assign head_loop   = q_loop[rd_ptr];

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      mis = 1'b0;
      if (pop)
         mis = (head_taken != bus.ex_taken) ||
               (bus.ex_taken && (head_target != bus.ex_target));
   end

   // A mispredict or trap makes every younger queued entry (and any concurrent push) wrong-path.
   assign clear = mis || bus.ext_flush;

   // NOTE: queue storage has no reset; only pointers and count qualify its contents.
   always_ff @(posedge cpu_clk) begin
      if (push_ok && !clear) begin
         q_pc[wr_ptr]     <= bus.dec_br_pc;
         q_target[wr_ptr] <= bus.dec_pred_target;
         q_taken[wr_ptr]  <= bus.dec_pred_taken;
         q_loop[wr_ptr]   <= bus.dec_is_loop;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         bus.upd_valid      <= 1'b0;
         bus.upd_pc         <= '0;
         bus.upd_taken      <= 1'b0;
         bus.upd_target     <= '0;
         bus.upd_is_loop    <= 1'b0;
         bus.upd_jalr       <= 1'b0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.q_err          <= 1'b0;
      end else begin
         bus.upd_valid <= pop;
         if (pop) begin
            bus.upd_pc      <= head_pc;
            bus.upd_taken   <= bus.ex_taken;
            bus.upd_target  <= bus.ex_target;
            bus.upd_is_loop <= head_loop;
            bus.upd_jalr    <= bus.ex_is_jalr;
         end
         // The trap handler owns the redirect when ext_flush coincides with a mispredict.
         bus.redirect_valid <= mis && !bus.ext_flush;
         if (mis && !bus.ext_flush)
            bus.redirect_pc <= bus.ex_taken ? bus.ex_target : head_pc + ADDR_WIDTH'(4);
         if (bus.ex_br_valid && (count == '0))
            bus.q_err <= 1'b1;
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         stat_resolved    <= '0;
         stat_mispred     <= '0;
         stat_target_miss <= '0;
      end else begin
         if (pop && (stat_resolved != '1))
            stat_resolved <= stat_resolved + 1'b1;
         if (mis && (stat_mispred != '1))
            stat_mispred <= stat_mispred + 1'b1;
         if (mis && (head_taken == bus.ex_taken) && (stat_target_miss != '1))
            stat_target_miss <= stat_target_miss + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed-vector bench for branch_resolve with hand-computed expectations.
// Stat counters are checked when BRANCH_STATS_EN is defined.
module tb_branch_resolve;
   localparam int AW = 32;
   localparam int QD = 4;

   logic cpu_clk = 1'b0;
   logic cpu_rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 cpu_clk = ~cpu_clk;

   branch_resolve_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_resolved, stat_mispred, stat_target_miss;
`endif

   branch_resolve #(.ADDR_WIDTH(AW), .QDEPTH(QD)) dut (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (bus)
`ifdef BRANCH_STATS_EN
      ,
      .stat_resolved    (stat_resolved),
      .stat_mispred     (stat_mispred),
      .stat_target_miss (stat_target_miss)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic idle();
      bus.dec_br_push     = 1'b0;
      bus.dec_br_pc       = '0;
      bus.dec_pred_taken  = 1'b0;
      bus.dec_pred_target = '0;
      bus.dec_is_loop     = 1'b0;
      bus.ex_br_valid     = 1'b0;
      bus.ex_is_jalr      = 1'b0;
      bus.ex_taken        = 1'b0;
      bus.ex_target       = '0;
      bus.ext_flush       = 1'b0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                           input logic loop);
      bus.dec_br_push     = 1'b1;
      bus.dec_br_pc       = pc;
      bus.dec_pred_taken  = pt;
      bus.dec_pred_target = tgt;
      bus.dec_is_loop     = loop;
   endtask

   task automatic set_resolve(input logic taken, input logic [31:0] tgt, input logic jalr);
      bus.ex_br_valid = 1'b1;
      bus.ex_taken    = taken;
      bus.ex_target   = tgt;
      bus.ex_is_jalr  = jalr;
   endtask

   task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                       input logic loop);
      set_push(pc, pt, tgt, loop);
      tick();
      idle();
   endtask

   logic [31:0] drain_exp [4];

   initial begin
      idle();
      cpu_rst = 1'b1;
      tick();
      tick();
      cpu_rst = 1'b0;

      check("rst_stall",     bus.dec_stall, 0);
      check("rst_upd_valid", bus.upd_valid, 0);
      check("rst_redir",     bus.redirect_valid, 0);
      check("rst_redir_pc",  bus.redirect_pc, 0);
      check("rst_upd_pc",    bus.upd_pc, 0);
      check("rst_upd_tgt",   bus.upd_target, 0);
      check("rst_q_err",     bus.q_err, 0);

      // Correct not-taken prediction
      push(32'h100, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b0, 32'h104, 1'b0);
      tick();
      idle();
      check("nt_upd_valid", bus.upd_valid, 1);
      check("nt_upd_pc",    bus.upd_pc, 32'h100);
      check("nt_upd_taken", bus.upd_taken, 0);
      check("nt_upd_tgt",   bus.upd_target, 32'h104);
      check("nt_redir",     bus.redirect_valid, 0);
      tick();
      check("nt_upd_pulse", bus.upd_valid, 0);

      // Direction mispredict
      push(32'h200, 1'b0, 32'h0, 1'b1);
      set_resolve(1'b1, 32'h240, 1'b0);
      tick();
      idle();
      check("dir_redir",    bus.redirect_valid, 1);
      check("dir_redir_pc", bus.redirect_pc, 32'h240);
      check("dir_loop",     bus.upd_is_loop, 1);
      check("dir_taken",    bus.upd_taken, 1);
      tick();
      check("dir_redir_pulse", bus.redirect_valid, 0);

      // Target mispredict on jalr
      push(32'h300, 1'b1, 32'h400, 1'b0);
      set_resolve(1'b1, 32'h480, 1'b1);
      tick();
      idle();
      check("tgt_redir",    bus.redirect_valid, 1);
      check("tgt_redir_pc", bus.redirect_pc, 32'h480);
      check("tgt_jalr",     bus.upd_jalr, 1);
      check("tgt_upd_pc",   bus.upd_pc, 32'h300);
      tick();

      // Not-taken mispredict: fall-through wraps past the top of the address space
      push(32'hFFFF_FFFC, 1'b1, 32'h500, 1'b0);
      set_resolve(1'b0, 32'h0, 1'b0);
      tick();
      idle();
      check("wrap_redir",    bus.redirect_valid, 1);
      check("wrap_redir_pc", bus.redirect_pc, 32'h0);
      check("wrap_jalr",     bus.upd_jalr, 0);
      tick();

      // Full queue; push during a pop while full is refused
      for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
      check("full_stall", bus.dec_stall, 1);
      set_push(32'h2000, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b0, 32'h0, 1'b0);
      #1;
      check("full_stall_pop", bus.dec_stall, 1);
      tick();
      idle();
      check("full_pop_pc",    bus.upd_pc, 32'h1000);
      check("full_pop_redir", bus.redirect_valid, 0);
      check("full_freed",     bus.dec_stall, 0);
      push(32'h3000, 1'b0, 32'h0, 1'b0);
      check("full_again", bus.dec_stall, 1);
      drain_exp = '{32'h1004, 32'h1008, 32'h100C, 32'h3000};
      for (int i = 0; i < 4; i++) begin
         set_resolve(1'b0, 32'h0, 1'b0);
         tick();
         check($sformatf("drain_pc%0d", i), bus.upd_pc, drain_exp[i]);
         check($sformatf("drain_v%0d", i),  bus.upd_valid, 1);
      end
      idle();
      tick();
      check("drain_empty_err", bus.q_err, 0);

`ifdef BRANCH_STATS_EN
      check("stat_resolved", stat_resolved, 9);
      check("stat_mispred",  stat_mispred, 3);
      check("stat_tmiss",    stat_target_miss, 1);
`endif

      // Mispredict with a concurrent wrong-path push; then resolve on the empty queue
      push(32'h600, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b1, 32'h700, 1'b0);
      set_push(32'h800, 1'b0, 32'h0, 1'b0);
      tick();
      idle();
      check("race_redir",    bus.redirect_valid, 1);
      check("race_redir_pc", bus.redirect_pc, 32'h700);
      set_resolve(1'b0, 32'h0, 1'b0);
      tick();
      idle();
      check("empty_upd",   bus.upd_valid, 0);
      check("empty_redir", bus.redirect_valid, 0);
      check("empty_q_err", bus.q_err, 1);
      tick();
      tick();
      check("q_err_sticky", bus.q_err, 1);

      // Reset mid-operation drops an in-progress mispredict response
      push(32'h900, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b1, 32'h940, 1'b0);
      cpu_rst = 1'b1;
      tick();
      cpu_rst = 1'b0;
      idle();
      check("mrst_redir", bus.redirect_valid, 0);
      check("mrst_upd",   bus.upd_valid, 0);
      check("mrst_q_err", bus.q_err, 0);
      check("mrst_rpc",   bus.redirect_pc, 0);
      push(32'hA00, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b0, 32'h0, 1'b0);
      tick();
      idle();
      check("mrst_head_pc", bus.upd_pc, 32'hA00);
`ifdef BRANCH_STATS_EN
      check("mrst_stat_res", stat_resolved, 1);
      check("mrst_stat_mis", stat_mispred, 0);
`endif

      // ext_flush racing a mispredicting resolve and a push
      push(32'hB00, 1'b0, 32'h0, 1'b0);
      push(32'hC00, 1'b0, 32'h0, 1'b0);
      set_resolve(1'b1, 32'hD00, 1'b0);
      set_push(32'hE00, 1'b0, 32'h0, 1'b0);
      bus.ext_flush = 1'b1;
      tick();
      idle();
      check("flush_upd",    bus.upd_valid, 1);
      check("flush_upd_pc", bus.upd_pc, 32'hB00);
      check("flush_redir",  bus.redirect_valid, 0);
      set_resolve(1'b0, 32'h0, 1'b0);
      tick();
      idle();
      check("flush_empty_upd", bus.upd_valid, 0);
      check("flush_empty_err", bus.q_err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
